// File: rtl/shared_acc_pkg.sv
// Shared definitions for the shared accumulator arbiter: FSM state encoding,
// operation encoding and the round-robin index helpers used by the arbiter.
// Optional feature macro (used by shared_acc_reg): SHARED_ACC_SAT_EN.
package shared_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_CLR = 1'b1;

  // Index vectors are sized for the largest supported requester count.
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  // First set request at or above ptr, wrapping at n; returns ptr if none.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] rq,
                                               input logic [IDX_W-1:0]   ptr,
                                               input int                 n);
    logic             found;
    logic [IDX_W-1:0] cand;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % n);
      if ((k < n) && !found && rq[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

  // Pointer position just after the last winner, wrapping at n.
  function automatic logic [IDX_W-1:0] rr_next_idx(input logic [IDX_W-1:0] idx,
                                                   input int               n);
    rr_next_idx = IDX_W'((int'(idx) + 1) % n);
  endfunction

endpackage

// File: rtl/shared_acc_reg.sv
// Clearable W-bit accumulate cell with sticky overflow flag.
// SHARED_ACC_SAT_EN defined: adds saturate at 2^W-1; otherwise they wrap.
// Either way ovf records any add that did not fit and holds until cleared.
module shared_acc_reg
  import shared_acc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         clr,
  input  logic         add_en,
  input  logic [W-1:0] addend,
  output logic [W-1:0] acc,
  output logic         ovf
);

  logic [W:0] add_res;

  // Returns {overflow_flag, result} for one unsigned accumulate step.
  function automatic logic [W:0] acc_add(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef SHARED_ACC_SAT_EN
    if (s[W]) begin
      acc_add = {1'b1, {W{1'b1}}};
    end else begin
      acc_add = s;
    end
`else
    acc_add = s;
`endif
  endfunction

  assign add_res = acc_add(acc, addend);

  // Accumulator register: clear beats add, overflow is sticky.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (add_en) begin
      acc <= add_res[W-1:0];
      ovf <= ovf | add_res[W];
    end
  end

endmodule

// File: rtl/shared_acc_arbiter.sv
// Round-robin arbiter sharing one accumulator among N_REQ requesters over a
// four-phase req/gnt handshake. One operation is applied per grant.
// Optional feature macro (consumed by shared_acc_reg): SHARED_ACC_SAT_EN.
module shared_acc_arbiter
  import shared_acc_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               CLR,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   op,
  input  logic [N_REQ*W-1:0] data,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic [W-1:0]       acc,
  output logic               ovf
);

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   win_idx, win_n;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   gnt_n;
  logic [MAX_REQ-1:0] req_ext;
  logic               latch_en;
  logic               op_sel, op_l;
  logic [W-1:0]       data_sel, data_l;
  logic               exec_cmt, clr_cmd, add_cmd;

  // Widen the request vector so the package search handles any N_REQ.
  always_comb begin
    req_ext = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ext[i] = req[i];
    end
  end

  assign pick_idx = rr_pick(req_ext, ptr, N_REQ);

  // Operand mux for the requester that wins arbitration this cycle.
  always_comb begin
    op_sel   = OP_ADD;
    data_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        op_sel   = op[i];
        data_sel = data[i*W +: W];
      end
    end
  end

  // Next-state, pointer, winner and grant decisions.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    win_n    = win_idx;
    gnt_n    = gnt;
    latch_en = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          win_n    = pick_idx;
          latch_en = 1'b1;
          state_n  = EXEC;
        end
      end
      EXEC: begin
        for (int i = 0; i < N_REQ; i++) begin
          gnt_n[i] = (IDX_W'(i) == win_idx);
        end
        state_n = HOLD;
      end
      HOLD: begin
        // A winner that already dropped req during EXEC exits here too,
        // which yields its one-cycle grant.
        if (!req_ext[win_idx]) begin
          gnt_n   = '0;
          ptr_n   = rr_next_idx(win_idx, N_REQ);
          state_n = IDLE;
        end
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Control registers; an asynchronous reset aborts any transaction.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      ptr     <= '0;
      win_idx <= '0;
      gnt     <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      win_idx <= win_n;
      gnt     <= gnt_n;
    end
  end

  // Operand latch: captured at arbitration, later input changes are ignored.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      op_l   <= op_sel;
      data_l <= data_sel;
    end
  end

  assign busy     = (state != IDLE);
  assign exec_cmt = (state == EXEC);
  // CLR wins over a same-cycle commit; the grant sequence still proceeds.
  assign clr_cmd  = CLR | (exec_cmt & (op_l == OP_CLR));
  assign add_cmd  = exec_cmt & (op_l == OP_ADD) & ~CLR;

  shared_acc_reg #(
    .W (W)
  ) u_acc (
    .clk    (clk),
    .RST    (RST),
    .clr    (clr_cmd),
    .add_en (add_cmd),
    .addend (data_l),
    .acc    (acc),
    .ovf    (ovf)
  );

endmodule

// File: tb/tb_shared_acc_arbiter.sv
// Self-checking bench for shared_acc_arbiter (N_REQ=4, W=8): reset state,
// a hand-computed transaction table, multi-cycle corner sequences and a
// randomized run against a transaction-level reference model.
module tb_shared_acc_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         RST;
  logic         CLR;
  logic [N-1:0] req;
  logic [N-1:0] op;
  logic [N*W-1:0] data;
  logic [N-1:0] gnt;
  logic         busy;
  logic [W-1:0] acc;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  // reference model state
  int acc_m;
  int ovf_m;
  int ptr_m;

  typedef struct {
    logic [3:0]  rq;
    logic [3:0]  ops;
    logic [31:0] dat;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_acc;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  shared_acc_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk  (clk),
    .RST  (RST),
    .CLR  (CLR),
    .req  (req),
    .op   (op),
    .data (data),
    .gnt  (gnt),
    .busy (busy),
    .acc  (acc),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    req = '0; op = '0; data = '0; CLR = 1'b0;
    RST = 1'b1;
    repeat (2) @(negedge clk);
    RST = 1'b0;
    acc_m = 0; ovf_m = 0; ptr_m = 0;
  endtask

  // One full handshake: raise, wait for grant, drop all, check release.
  task automatic run_txn(input logic [3:0] m, input logic [3:0] ops, input logic [31:0] d,
                         output logic [3:0] g, output logic [7:0] a, output logic o);
    int lat;
    @(negedge clk);
    req = m; op = ops; data = d; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy_after_req", 32'(busy), 32'd1);
    end while (gnt == 4'b0 && lat < 20);
    check("grant_latency", 32'(lat), 32'd2);
    g = gnt; a = acc; o = ovf;
    req = '0;
    @(negedge clk);
    check("drop_gnt", 32'(gnt), 32'd0);
    check("drop_busy", 32'(busy), 32'd0);
  endtask

  // Model: winner is first request at or after ptr_m with wrap.
  function automatic int model_winner(input logic [3:0] m);
    for (int k = 0; k < N; k++) begin
      if (m[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic model_apply(input logic o, input int d);
    int s;
    if (o) begin
      acc_m = 0; ovf_m = 0;
    end else begin
      s = acc_m + d;
`ifdef SHARED_ACC_SAT_EN
      if (s > 255) begin acc_m = 255; ovf_m = 1; end
      else acc_m = s;
`else
      if (s > 255) ovf_m = 1;
      acc_m = s % 256;
`endif
    end
  endtask

  initial begin
    logic [3:0] g;
    logic [7:0] a;
    logic       o;
    int         order[5];
    int         n_g;
    int         cyc;

    // expected values worked by hand from the arbitration and add rules
    vecs[0] = '{4'b0100, 4'b0000, 32'h00050000, 4'b0100, 8'h05, 1'b0};
    vecs[1] = '{4'b0011, 4'b0000, 32'h00002010, 4'b0001, 8'h15, 1'b0};
    vecs[2] = '{4'b0011, 4'b0000, 32'h00002010, 4'b0010, 8'h35, 1'b0};
    vecs[3] = '{4'b1000, 4'b0000, 32'hBB000000, 4'b1000, 8'hF0, 1'b0};
`ifdef SHARED_ACC_SAT_EN
    vecs[4] = '{4'b0010, 4'b0000, 32'h00002000, 4'b0010, 8'hFF, 1'b1};
`else
    vecs[4] = '{4'b0010, 4'b0000, 32'h00002000, 4'b0010, 8'h10, 1'b1};
`endif
    vecs[5] = '{4'b0001, 4'b0001, 32'h000000AA, 4'b0001, 8'h00, 1'b0};
    vecs[6] = '{4'b1111, 4'b0000, 32'h01010101, 4'b0010, 8'h01, 1'b0};

    // reset state
    do_reset();
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // table-driven transactions
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].rq, vecs[i].ops, vecs[i].dat, g, a, o);
      check($sformatf("tbl%0d_gnt", i), 32'(g), 32'(vecs[i].exp_gnt));
      check($sformatf("tbl%0d_acc", i), 32'(a), 32'(vecs[i].exp_acc));
      check($sformatf("tbl%0d_ovf", i), 32'(o), 32'(vecs[i].exp_ovf));
    end

    // all four requesting, each drops right after its grant
    do_reset();
    @(negedge clk);
    op = '0; data = 32'h01010101; req = 4'b1111;
    n_g = 0; cyc = 0;
    while (n_g < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (gnt[i] && req[i]) begin
          if (n_g < 5) order[n_g] = i;
          n_g++;
          req[i] = 1'b0;
        end else if (!req[i] && !gnt[i] && n_g < 5) begin
          req[i] = 1'b1;
        end
      end
    end
    check("rr_count", 32'(n_g), 32'd5);
    req = '0;
    @(negedge clk);
    check("rr_release", 32'(gnt), 32'd0);
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 4));
    check("rr_acc", 32'(acc), 32'h05);

    // CLR during the EXEC cycle of add 0x07 from acc 0x03
    do_reset();
    run_txn(4'b0001, 4'b0000, 32'h00000003, g, a, o);
    check("clr_pre_acc", 32'(a), 32'h03);
    @(negedge clk);
    req = 4'b0001; op = '0; data = 32'h00000007;
    @(negedge clk);
    check("clr_exec_busy", 32'(busy), 32'd1);
    CLR = 1'b1;
    @(negedge clk);
    CLR = 1'b0;
    check("clr_gnt", 32'(gnt), 32'b0001);
    check("clr_acc", 32'(acc), 32'd0);
    check("clr_ovf", 32'(ovf), 32'd0);
    req = '0;
    @(negedge clk);
    check("clr_release", 32'(gnt), 32'd0);
    check("clr_discard", 32'(acc), 32'd0);

    // req[1] dropped during EXEC with add 0x02 (acc is 0 here)
    @(negedge clk);
    req = 4'b0010; op = '0; data = 32'h00000200;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    check("early_gnt", 32'(gnt), 32'b0010);
    check("early_acc", 32'(acc), 32'h02);
    @(negedge clk);
    check("early_gnt_off", 32'(gnt), 32'd0);
    check("early_busy_off", 32'(busy), 32'd0);
    @(negedge clk);
    check("early_acc_hold", 32'(acc), 32'h02);

    // RST during EXEC with acc 0x10; ptr moved to 2 beforehand
    do_reset();
    run_txn(4'b0010, 4'b0000, 32'h00001000, g, a, o);
    check("rstx_pre_acc", 32'(a), 32'h10);
    @(negedge clk);
    req = 4'b0100; data = 32'h00050000;
    @(negedge clk);
    check("rstx_exec_busy", 32'(busy), 32'd1);
    RST = 1'b1;
    #1;
    check("rstx_acc", 32'(acc), 32'd0);
    check("rstx_gnt", 32'(gnt), 32'd0);
    check("rstx_busy", 32'(busy), 32'd0);
    req = '0;
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    check("rstx_not_applied", 32'(acc), 32'd0);
    run_txn(4'b1111, 4'b0000, 32'h01010101, g, a, o);
    check("rstx_ptr0_gnt", 32'(g), 32'b0001);
    check("rstx_after_acc", 32'(a), 32'h01);

    // randomized transactions against the reference model
    do_reset();
    for (int t = 0; t < 150; t++) begin
      logic [3:0]  m;
      logic [3:0]  ops;
      logic [31:0] d;
      int          w;
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        CLR = 1'b1;
        @(negedge clk);
        CLR = 1'b0;
        acc_m = 0; ovf_m = 0;
        check("rand_clr_acc", 32'(acc), 32'd0);
        check("rand_clr_ovf", 32'(ovf), 32'd0);
      end
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) ops[i] = ($urandom_range(0, 7) == 0);
      d = $urandom;
      w = model_winner(m);
      run_txn(m, ops, d, g, a, o);
      model_apply(ops[w], int'(d[w*8 +: 8]));
      ptr_m = (w + 1) % N;
      check("rand_gnt", 32'(g), 32'(1 << w));
      check("rand_acc", 32'(a), 32'(acc_m));
      check("rand_ovf", 32'(o), 32'(ovf_m));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_acc_arbiter.md
# shared_acc_arbiter

Round-robin controller that shares one W-bit accumulating register among N_REQ requesters. Each requester issues an add or clear operation through a four-phase req/gnt handshake; the block arbitrates, applies exactly one operation per grant, and exposes the running total plus a sticky overflow flag. It sits between event-producing blocks and the single accumulate register, which is built from the team's clearable accumulate-cell style.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- W, 8, accumulator width in bits

Ports:
- clk  input  1  clock; all state changes on rising edge
- RST  input  1  asynchronous, active-high reset
- CLR  input  1  synchronous global clear of acc and ovf, highest priority
- req  input  N_REQ  per-requester request level
- op  input  N_REQ  per-requester operation: 0 = add, 1 = clear
- data  input  N_REQ*W  per-requester addend, slice i = data[i*W +: W]
- gnt  output  N_REQ  one-hot grant level
- busy  output  1  high whenever state is not IDLE
- acc  output  W  accumulator value
- ovf  output  1  sticky overflow flag

## Operation
- States: IDLE, EXEC, HOLD.
- IDLE: if any req bit is high, select the winner by round-robin starting at ptr, searching upward with wrap. Latch win_idx, op[win_idx] and data slice, then go to EXEC. If no req bit is high, stay in IDLE.
- EXEC: commit the latched operation.
  - add: {carry, acc} = acc + data.
  - clear: acc = 0, ovf = 0.
  - Assert gnt[win_idx], then go to HOLD.
- HOLD: keep gnt[win_idx] asserted while req[win_idx] = 1. On the first sampled req[win_idx] = 0: drop gnt, set ptr = (win_idx + 1) mod N_REQ, go to IDLE.
- Operands are latched in IDLE. Changes to op or data after that point are ignored.
- A requester that drops req during EXEC still has its operation applied. It gets a one-cycle gnt, and HOLD exits on the next edge.
- Overflow without SAT_EN: acc wraps modulo 2^W. ovf is set when carry = 1 and stays set until a clear op, CLR or RST.
- CLR has priority over any EXEC commit in the same cycle: acc = 0 and ovf = 0, and the latched operation is discarded. The FSM and gnt sequencing are unaffected, so the requester is still granted.
- Requesters other than the winner are not acknowledged until a later IDLE arbitration.

## Timing
- Reset values: state = IDLE, ptr = 0, gnt = 0, busy = 0, acc = 0, ovf = 0.
- RST asserted mid-transaction aborts immediately. Any uncommitted operation is lost.
- Request sampled in IDLE at edge k gives:
  - busy = 1 after edge k;
  - acc/ovf updated and gnt = 1 after edge k+1.
- Request drop sampled at edge m gives gnt = 0 and busy = 0 after edge m.
- Minimum transaction is 3 cycles (IDLE, EXEC, HOLD). Back-to-back arbitration resumes in the IDLE cycle that follows.
- acc, ovf, gnt and busy are all registered. There are no combinational paths from inputs to outputs.

## Configuration
- SHARED_ACC_SAT_EN defined: add saturates at 2^W-1. ovf is set whenever saturation clips a result.
- SHARED_ACC_SAT_EN undefined: add wraps modulo 2^W. ovf is set on carry-out.
- In both cases ovf is sticky, and the clear and CLR semantics are identical.

## Structure
- shared_acc_pkg holds:
  - the state enum (IDLE, EXEC, HOLD);
  - op encoding constants OP_ADD = 1'b0 and OP_CLR = 1'b1;
  - a round-robin next-index function.
- One sub-module, shared_acc_reg: W-bit register with asynchronous RST, synchronous clear, add enable, sticky ovf and the SHARED_ACC_SAT_EN logic.
- shared_acc_arbiter contains only the FSM, ptr, operand latches and gnt.

## Test plan
- RST mid-EXEC with acc = 0x10: after RST, acc = 0, gnt = 0, busy = 0, state IDLE, ptr = 0; the pending operation is not applied.
- req[2] = 1, op = add, data = 0x05 from acc = 0:
  - gnt[2] rises 2 edges later with acc = 0x05;
  - req[2] drop leads to gnt[2] = 0 and busy = 0 on the next edge.
- All four req held high, each dropped one cycle after its gnt: grant order 0, 1, 2, 3, 0; each adds 0x01, so acc = 0x05.
- acc = 0xF0, add 0x20:
  - without SAT_EN: acc = 0x10, ovf = 1;
  - with SHARED_ACC_SAT_EN: acc = 0xFF, ovf = 1;
  - then a clear op gives acc = 0, ovf = 0.
- CLR pulsed in the EXEC cycle of add 0x07 from acc = 0x03: acc = 0, gnt still asserts, ovf = 0.
- req[1] dropped during EXEC with add 0x02: acc increments by 0x02, gnt[1] is high for exactly one cycle, and the block returns to IDLE.
